lifo_stack_ptr: RTL
===================

// Module: lifo_stack_ptr
// PURPOSE
//  Pointer-based, parametrised LIFO; successor to the shift-register stack.
//  Storage is a register file addressed by a stack pointer, so no per-push data shuffle.
//  Adds full/empty/almost_full/count status, a registered pop result with valid strobe,
//  same-cycle push+pop (replace-top), synchronous flush and sticky overflow/underflow flags.
//  Used as a general scratch/return stack for local controllers.
// PARAMETERS
//  DATA_WIDTH   8   width of each entry
//  DEPTH        16  number of entries, >= 2, any integer (not restricted to powers of two)
//  ALMOST_FULL  12  almost_full asserts when count >= ALMOST_FULL; 1..DEPTH
// PORTS
//  clk          in   1               clock, all state on rising edge
//  rst          in   1               asynchronous, active-low reset
//  push         in   1               push write_data
//  pop          in   1               pop top entry
//  flush        in   1               synchronous empty-the-stack
//  err_clr      in   1               clear sticky error flags
//  write_data   in   DATA_WIDTH      data to push
//  read_data    out  DATA_WIDTH      registered popped data, holds until next pop
//  read_valid   out  1               1-cycle strobe: read_data updated this cycle
//  top          out  DATA_WIDTH      combinational peek of top entry, 0 when empty
//  count        out  CW              entries held, CW = $clog2(DEPTH+1)
//  empty        out  1               count == 0
//  full         out  1               count == DEPTH
//  almost_full  out  1               count >= ALMOST_FULL
//  overflow     out  1               sticky: push rejected while full
//  underflow    out  1               sticky: pop rejected while empty
// BEHAVIOUR
//  - Reset (rst=0, async): sp=0, read_data=0, read_valid=0, overflow=underflow=0.
//    Storage array is NOT reset; top reads 0 because empty=1.
//  - sp in 0..DEPTH; count = sp; top = mem[sp-1] when sp != 0.
//  - Priority per cycle: flush > push/pop. flush: sp<=0, read_valid<=0, read_data holds.
//  - push only: if !full -> mem[sp]<=write_data, sp<=sp+1; if full -> dropped, overflow<=1.
//  - pop only: if !empty -> read_data<=mem[sp-1], read_valid<=1, sp<=sp-1;
//    if empty -> ignored, underflow<=1, read_valid<=0.
//  - push+pop, not empty (incl. full): read_data<=old top, read_valid<=1,
//    mem[sp-1]<=write_data, sp unchanged; no error.
//  - push+pop, empty: bypass: read_data<=write_data, read_valid<=1, sp stays 0; no error.
//  - Latency: pop result visible one cycle after the pop edge; status flags and top
//    reflect the new sp in the cycle after the edge (all derived from registered sp).
//  - read_valid is 0 in every cycle that does not follow an accepted pop.
//  - err_clr clears overflow/underflow; a same-cycle new error wins (flag stays 1).
//  - Errors are not cleared by flush; only err_clr or reset.
//  - Reset mid-operation: any in-flight pop result is discarded (read_valid=0, read_data=0).
// STRUCTURE
//  - Shared include stack_pkg.vh: CW computation macro, status bit indices for
//    a future CSR view; no per-instance constants.
//  - One sub-module: stack_regfile (DEPTH x DATA_WIDTH, 1 sync write port, 2 async
//    read ports: mem[sp-1] for top/pop, none reset). Controller (sp, flags, read_data)
//    stays in lifo_stack_ptr.
// TESTING (DATA_WIDTH=8, DEPTH=4, ALMOST_FULL=3)
//  - Reset, then push 11,22,33 -> count=3, almost_full=1, top=33; pop x3 -> read_data
//    33,22,11 each with 1-cycle read_valid; empty=1, top=0.
//  - Push 5 values 1..5 -> full=1 after 4th, 5th dropped, overflow=1; pop -> read_data=4.
//  - Pop on empty -> underflow=1, read_valid=0, read_data unchanged; err_clr -> underflow=0.
//  - Stack {AA,BB}, push+pop with CC -> read_data=BB, read_valid=1, count=2, top=CC;
//    empty stack push+pop with 5A -> read_data=5A, read_valid=1, count=0.
//  - Full stack, flush with push=1 -> count=0, empty=1, overflow unchanged, no write.
//  - Assert rst low mid-pop (async, between edges) -> outputs 0 immediately, count=0.

Source files
------------

// File: rtl/lifo_stack_ptr_pkg.sv
// Shared definitions for the pointer-based LIFO: count-width helper, status bit
// positions for a CSR view, and the per-cycle operation decode.
package lifo_stack_ptr_pkg;

    // count must hold DEPTH itself, hence DEPTH+1 codes
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int STAT_EMPTY       = 0;
    localparam int STAT_FULL        = 1;
    localparam int STAT_ALMOST_FULL = 2;
    localparam int STAT_OVERFLOW    = 3;
    localparam int STAT_UNDERFLOW   = 4;
    localparam int STAT_W           = 5;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_FLUSH,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_BYPASS
    } op_e;

endpackage

// File: rtl/lifo_stack_ptr_if.sv
// Command/status bundle of the LIFO; master drives commands, slave is the stack.
interface lifo_stack_ptr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    import lifo_stack_ptr_pkg::*;

    localparam int CW = calc_cw(DEPTH);

    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic [DATA_WIDTH-1:0] top;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, flush, err_clr, write_data,
        input  read_data, read_valid, top, count, empty, full, almost_full,
               overflow, underflow
    );

    modport slave (
        input  push, pop, flush, err_clr, write_data,
        output read_data, read_valid, top, count, empty, full, almost_full,
               overflow, underflow
    );

endinterface

// File: rtl/lifo_stack_ptr_regfile.sv
// Stack storage: DEPTH x DATA_WIDTH, one synchronous write port and two
// asynchronous read ports (peek and pop capture).
module lifo_stack_ptr_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]         raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; entries above sp are never observed, and
    // leaving the array unreset lets it map onto plain register-file cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lifo_stack_ptr.sv
// Pointer-based LIFO controller: stack pointer, registered pop result, sticky
// error flags; storage lives in lifo_stack_ptr_regfile.
module lifo_stack_ptr
    import lifo_stack_ptr_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input logic               clk,
    input logic               rst,
    lifo_stack_ptr_if.slave   bus
);

    localparam int CW = calc_cw(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]         sp;
    logic [AW-1:0]         top_addr;
    logic [AW-1:0]         wr_addr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] peek_data;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  is_empty;
    logic                  is_full;
    op_e                   op;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == CW'(DEPTH));
    assign top_addr = AW'(sp - CW'(1));

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        op = OP_IDLE;
        if (bus.flush) begin
            op = OP_FLUSH;
        end else if (bus.push && bus.pop) begin
            op = is_empty ? OP_BYPASS : OP_REPLACE;
        end else if (bus.push) begin
            op = OP_PUSH;
        end else if (bus.pop) begin
            op = OP_POP;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = AW'(sp);
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (op)
            OP_PUSH: begin
                wr_en   = !is_full;
                ovf_set = is_full;
            end
            OP_POP: begin
                unf_set = is_empty;
            end
            OP_REPLACE: begin
                wr_en   = 1'b1;
                wr_addr = top_addr;
            end
            default: ;
        endcase
    end

    lifo_stack_ptr_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_regfile (
        .clk     (clk),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (bus.write_data),
        .raddr_a (top_addr),
        .rdata_a (peek_data),
        .raddr_b (top_addr),
        .rdata_b (pop_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp           <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            read_valid_q <= 1'b0;
            case (op)
                OP_FLUSH: sp <= '0;
                OP_PUSH: begin
                    if (!is_full) sp <= sp + CW'(1);
                end
                OP_POP: begin
                    if (!is_empty) begin
                        sp           <= sp - CW'(1);
                        read_data_q  <= pop_data;
                        read_valid_q <= 1'b1;
                    end
                end
                OP_REPLACE: begin
                    read_data_q  <= pop_data;
                    read_valid_q <= 1'b1;
                end
                OP_BYPASS: begin
                    read_data_q  <= bus.write_data;
                    read_valid_q <= 1'b1;
                end
                default: ;
            endcase
            // a new error in the clearing cycle keeps the flag set
            overflow_q  <= (overflow_q  & ~bus.err_clr) | ovf_set;
            underflow_q <= (underflow_q & ~bus.err_clr) | unf_set;
        end
    end

    assign bus.read_data   = read_data_q;
    assign bus.read_valid  = read_valid_q;
    assign bus.top         = is_empty ? '0 : peek_data;
    assign bus.count       = sp;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (sp >= CW'(ALMOST_FULL));
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule
